// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM state codes and counter sizing.
package reset_seq_pkg;

    typedef logic [1:0] state_t;

    localparam state_t HOLD     = 2'd0;
    localparam state_t REL_WAIT = 2'd1;
    localparam state_t GAP      = 2'd2;
    localparam state_t DONE     = 2'd3;

    // Wide enough to hold the largest of the three limits without wrapping.
    function automatic int unsigned cnt_w(input int unsigned a, input int unsigned b,
                                          input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/seq_cnt.sv
// Loadable saturating up-counter with clear; flags the edge on which the limit is reached.
module seq_cnt #(
    parameter int unsigned W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic         last
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (en && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // High when the current enabled edge is the limit-th one since the last clear.
    assign last = en && (cnt_q == (limit - 1'b1));

endmodule

// File: rtl/reset_sequencer.sv
// Releases NUM_STAGES reset domains in order, each after the previous reports ready or times out.
module reset_sequencer #(
    parameter int unsigned NUM_STAGES = 4,
    parameter int unsigned MIN_ASSERT = 4,
    parameter int unsigned STAGE_DLY  = 2,
    parameter int unsigned TMO_CYC    = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sw_rst_req,
    input  logic [NUM_STAGES-1:0]         stage_rdy,
    output logic [NUM_STAGES-1:0]         stage_rstn,
    output logic [$clog2(NUM_STAGES):0]   cur_stage,
    output logic                          seq_done,
    output logic                          seq_err
);
    import reset_seq_pkg::*;

    localparam int unsigned CW = cnt_w(MIN_ASSERT, STAGE_DLY, TMO_CYC);
    localparam int unsigned SW = $clog2(NUM_STAGES) + 1;

    state_t                state_q, state_d;
    logic [NUM_STAGES-1:0] rstn_d;
    logic [SW-1:0]         cur_d;
    logic                  done_d, err_d;
    logic                  cnt_clr, cnt_en, cnt_last;
    logic [CW-1:0]         cnt_limit;
    logic                  rdy_cur;
    logic                  last_stage;

    seq_cnt #(
        .W (CW)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (cnt_clr),
        .load     (1'b0),
        .load_val ({CW{1'b0}}),
        .en       (cnt_en),
        .limit    (cnt_limit),
        .last     (cnt_last)
    );

    always_comb begin
        rdy_cur = 1'b0;
        for (int unsigned k = 0; k < NUM_STAGES; k++) begin
            if (cur_stage == SW'(k)) rdy_cur = stage_rdy[k];
        end
    end

    assign last_stage = (cur_stage == SW'(NUM_STAGES - 1));

    always_comb begin
        state_d   = state_q;
        rstn_d    = stage_rstn;
        cur_d     = cur_stage;
        done_d    = seq_done;
        err_d     = seq_err;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        cnt_limit = '0;

        if (sw_rst_req) begin
            state_d = HOLD;
            rstn_d  = '0;
            cur_d   = '0;
            done_d  = 1'b0;
            err_d   = 1'b0;
            cnt_clr = 1'b1;
        end else begin
            case (state_q)
                HOLD: begin
                    cnt_limit = CW'(MIN_ASSERT);
                    cnt_en    = 1'b1;
                    if (cnt_last) begin
                        rstn_d[0] = 1'b1;
                        cur_d     = '0;
                        state_d   = REL_WAIT;
                        cnt_clr   = 1'b1;
                    end
                end
                REL_WAIT: begin
                    cnt_limit = CW'(TMO_CYC);
                    cnt_en    = !rdy_cur;
                    // Ready wins over a coincident timeout, so the error only sets without ready.
                    if (rdy_cur || cnt_last) begin
                        if (!rdy_cur) err_d = 1'b1;
                        cnt_clr = 1'b1;
                        if (last_stage) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = GAP;
                        end
                    end
                end
                GAP: begin
                    cnt_limit = CW'(STAGE_DLY);
                    cnt_en    = 1'b1;
                    if (cnt_last) begin
                        for (int unsigned k = 0; k < NUM_STAGES; k++) begin
                            if (SW'(k) == cur_stage + 1'b1) rstn_d[k] = 1'b1;
                        end
                        cur_d   = cur_stage + 1'b1;
                        state_d = REL_WAIT;
                        cnt_clr = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= HOLD;
            stage_rstn <= '0;
            cur_stage  <= '0;
            seq_done   <= 1'b0;
            seq_err    <= 1'b0;
        end else begin
            state_q    <= state_d;
            stage_rstn <= rstn_d;
            cur_stage  <= cur_d;
            seq_done   <= done_d;
            seq_err    <= err_d;
        end
    end

endmodule
